// File: rtl/cv32e40p_xmem_obi_bridge.sv
// -----------------------------------------------------------------------------
// cv32e40p_xmem_obi_bridge
//
// Converts Xmem memory requests from the CV-X-IF accelerator wrapper into OBI
// data-bus transactions and returns Xmem responses in request order.
//
// Datapath:
//   request register -> OBI request (held until grant)
//   on grant         -> meta FIFO entry {width, byte offset, we}
//   on rvalid        -> meta pop, response FIFO push {rdata, range, status}
//   response FIFO    -> Xmem response channel
//
// A credit counter (request register + meta FIFO + response FIFO occupancy)
// limits in-flight requests to DEPTH.
//
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   xmem_q_*                      Xmem request channel (valid/ready, laddr,
//                                 wdata, width, req_type; mode/spec/eot unused)
//   xmem_p_*                      Xmem response channel (valid/ready, rdata,
//                                 range, status)
//   data_req_o/data_gnt_i         OBI request handshake
//   data_addr_o/we_o/be_o/wdata_o OBI request payload
//   data_rvalid_i/rdata_i/err_i   OBI response
//
// Parameter:
//   DEPTH  maximum in-flight requests (1..8), default 2
//
// Build option:
//   CV32E40P_XMEM_MISALIGN_CHECK_EN  when defined, misaligned half/word
//   requests are answered locally with an error response and never reach the
//   bus. When undefined, every request goes to the bus and the low address
//   bits only steer byte lanes (upper bytes may be dropped).
// -----------------------------------------------------------------------------
module cv32e40p_xmem_obi_bridge #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // Xmem request channel
  input  logic        xmem_q_valid_i,
  output logic        xmem_q_ready_o,
  input  logic [31:0] xmem_q_laddr_i,
  input  logic [31:0] xmem_q_wdata_i,
  input  logic [2:0]  xmem_q_width_i,
  input  logic        xmem_q_req_type_i,
  input  logic        xmem_q_mode_i,
  input  logic        xmem_q_spec_i,
  input  logic        xmem_q_endoftransaction_i,
  // Xmem response channel
  output logic        xmem_p_valid_o,
  input  logic        xmem_p_ready_i,
  output logic [31:0] xmem_p_rdata_o,
  output logic [4:0]  xmem_p_range_o,
  output logic        xmem_p_status_o,
  // OBI data bus
  output logic        data_req_o,
  input  logic        data_gnt_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  input  logic        data_err_i
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    WIDTH_BYTE = 2'd0,
    WIDTH_HALF = 2'd1,
    WIDTH_WORD = 2'd2
  } width_e;

  typedef struct packed {
    width_e     width;
    logic [1:0] offset;
    logic       we;
  } meta_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [4:0]  rng;
    logic        err;
  } resp_t;

  // ---------------------------------------------------------------------------
  // Width helpers
  // ---------------------------------------------------------------------------
  function automatic logic [4:0] width_range(input width_e w);
    case (w)
      WIDTH_BYTE: return 5'd7;
      WIDTH_HALF: return 5'd15;
      default:    return 5'd31;
    endcase
  endfunction

  function automatic logic [31:0] width_mask(input width_e w);
    case (w)
      WIDTH_BYTE: return 32'h0000_00FF;
      WIDTH_HALF: return 32'h0000_FFFF;
      default:    return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [3:0] width_be(input width_e w);
    case (w)
      WIDTH_BYTE: return 4'b0001;
      WIDTH_HALF: return 4'b0011;
      default:    return 4'b1111;
    endcase
  endfunction

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic        req_full;
  logic [31:0] req_addr;
  logic        req_we;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  width_e      req_width;
  logic [1:0]  req_offset;

  meta_t              meta_mem [DEPTH];
  logic [PTR_W-1:0]   meta_wr_ptr, meta_rd_ptr;
  logic [CNT_W-1:0]   meta_cnt;

  resp_t              resp_mem [DEPTH];
  logic [PTR_W-1:0]   resp_wr_ptr, resp_rd_ptr;
  logic [CNT_W-1:0]   resp_cnt;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  width_e     q_width;
  logic [1:0] q_offset;
  logic       q_misaligned;

  // NOTE: every signal driven in an always_comb gets a default assignment first,
  // so no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    q_width = WIDTH_WORD;
    case (xmem_q_width_i)
      3'd0:    q_width = WIDTH_BYTE;
      3'd1:    q_width = WIDTH_HALF;
      default: q_width = WIDTH_WORD;
    endcase
  end

  assign q_offset = xmem_q_laddr_i[1:0];

`ifdef CV32E40P_XMEM_MISALIGN_CHECK_EN
  assign q_misaligned = ((q_width == WIDTH_HALF) && q_offset[0]) ||
                        ((q_width == WIDTH_WORD) && (q_offset != 2'b00));
`else
  assign q_misaligned = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Credits and accept
  // ---------------------------------------------------------------------------
  logic [5:0] credit_cnt;
  logic       meta_empty;
  logic       req_gnt;
  logic       q_accept;
  logic       bus_accept;
  logic       err_accept;

  assign meta_empty = (meta_cnt == '0);
  assign req_gnt    = req_full & data_gnt_i;
  assign credit_cnt = 6'(req_full) + 6'(meta_cnt) + 6'(resp_cnt);

  // A misaligned request is answered directly into the response FIFO, so it
  // must wait until no bus transaction is ahead of it to keep responses ordered.
  assign xmem_q_ready_o = (credit_cnt < 6'(DEPTH)) &&
                          (q_misaligned ? (!req_full && meta_empty)
                                        : (!req_full || data_gnt_i));

  assign q_accept   = xmem_q_valid_i & xmem_q_ready_o;
  assign bus_accept = q_accept & ~q_misaligned;
  assign err_accept = q_accept &  q_misaligned;

  // ---------------------------------------------------------------------------
  // Request register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated only with non-blocking assignments so all
  // registers sample their inputs on the same edge regardless of block order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_full   <= 1'b0;
      req_addr   <= '0;
      req_we     <= 1'b0;
      req_be     <= '0;
      req_wdata  <= '0;
      req_width  <= WIDTH_BYTE;
      req_offset <= '0;
    end else if (bus_accept) begin
      req_full   <= 1'b1;
      req_addr   <= {xmem_q_laddr_i[31:2], 2'b00};
      req_we     <= xmem_q_req_type_i;
      req_be     <= width_be(q_width) << q_offset;
      req_wdata  <= xmem_q_wdata_i << {q_offset, 3'b000};
      req_width  <= q_width;
      req_offset <= q_offset;
    end else if (req_gnt) begin
      req_full   <= 1'b0;
    end
  end

  assign data_req_o   = req_full;
  assign data_addr_o  = req_addr;
  assign data_we_o    = req_we;
  assign data_be_o    = req_be;
  assign data_wdata_o = req_wdata;

  // ---------------------------------------------------------------------------
  // Meta and response FIFOs
  // ---------------------------------------------------------------------------
  logic  meta_push, meta_pop;
  logic  resp_push, resp_pop;
  meta_t meta_head;
  resp_t resp_head;
  resp_t resp_wdata;
  logic [31:0] bus_rdata;

  assign meta_push = req_gnt;
  // An rvalid with nothing outstanding is a bus protocol error and is dropped.
  assign meta_pop  = data_rvalid_i & ~meta_empty;
  assign meta_head = meta_mem[meta_rd_ptr];

  assign xmem_p_valid_o = (resp_cnt != '0);
  assign resp_head      = resp_mem[resp_rd_ptr];
  assign resp_pop       = xmem_p_valid_o & xmem_p_ready_i;
  assign resp_push      = meta_pop | err_accept;

  always_comb begin
    bus_rdata = (data_rdata_i >> {meta_head.offset, 3'b000}) & width_mask(meta_head.width);
    if (meta_head.we) bus_rdata = '0;
  end

  // meta_pop and err_accept are mutually exclusive: a misaligned accept
  // requires the meta FIFO to be empty.
  always_comb begin
    resp_wdata = '0;
    if (err_accept) begin
      resp_wdata.rng = width_range(q_width);
      resp_wdata.err = 1'b1;
    end else begin
      resp_wdata.rdata = bus_rdata;
      resp_wdata.rng   = width_range(meta_head.width);
      resp_wdata.err   = data_err_i;
    end
  end

  // NOTE: the FIFO storage arrays have no reset; the occupancy counters qualify
  // every read and the response outputs are forced to zero while empty.
  always_ff @(posedge clk_i) begin
    if (meta_push) meta_mem[meta_wr_ptr] <= '{width: req_width, offset: req_offset, we: req_we};
    if (resp_push) resp_mem[resp_wr_ptr] <= resp_wdata;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_wr_ptr <= '0;
      meta_rd_ptr <= '0;
      meta_cnt    <= '0;
      resp_wr_ptr <= '0;
      resp_rd_ptr <= '0;
      resp_cnt    <= '0;
    end else begin
      if (meta_push) meta_wr_ptr <= ptr_next(meta_wr_ptr);
      if (meta_pop)  meta_rd_ptr <= ptr_next(meta_rd_ptr);
      unique case ({meta_push, meta_pop})
        2'b10:   meta_cnt <= meta_cnt + CNT_W'(1);
        2'b01:   meta_cnt <= meta_cnt - CNT_W'(1);
        default: ;
      endcase

      if (resp_push) resp_wr_ptr <= ptr_next(resp_wr_ptr);
      if (resp_pop)  resp_rd_ptr <= ptr_next(resp_rd_ptr);
      unique case ({resp_push, resp_pop})
        2'b10:   resp_cnt <= resp_cnt + CNT_W'(1);
        2'b01:   resp_cnt <= resp_cnt - CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign xmem_p_rdata_o  = xmem_p_valid_o ? resp_head.rdata : '0;
  assign xmem_p_range_o  = xmem_p_valid_o ? resp_head.rng   : '0;
  assign xmem_p_status_o = xmem_p_valid_o ? resp_head.err   : 1'b0;

  // Sideband request fields carry no meaning for this bridge.
  logic unused_inputs;
  assign unused_inputs = ^{xmem_q_mode_i, xmem_q_spec_i, xmem_q_endoftransaction_i};

  // The bus must never return a response that was not requested.
  assert property (@(posedge clk_i) disable iff (rst_i) !(data_rvalid_i && meta_empty));

endmodule
